// File: rtl/accel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | accel_pkg : shared types and constants for the accelerator front end     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package accel_pkg;

  localparam int                       ACCEL_ROM_ADDR_W = 8;
  localparam int                       ACCEL_INSTR_W    = 32;
  localparam logic [ACCEL_INSTR_W-1:0] ACCEL_HALT_WORD  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_unit : byte-serial ROM fetch, 4 bytes -> 32-bit instruction  |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module instr_fetch_unit
  import accel_pkg::*;
#(
  parameter int                       ROM_ADDR_W = ACCEL_ROM_ADDR_W,
  parameter logic [ROM_ADDR_W-1:0]    START_ADDR = '0,
  parameter logic [ACCEL_INSTR_W-1:0] HALT_WORD  = ACCEL_HALT_WORD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic [ROM_ADDR_W-1:0]    rom_address,
  input  logic [7:0]               data_from_rom,
  output logic [ACCEL_INSTR_W-1:0] instruction_in,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ROM_ADDR_W-1:0]    redirect_addr,
  output logic [ROM_ADDR_W-1:0]    pc,
  output logic                     halted
);

  localparam logic [ROM_ADDR_W-1:0] ADDR_ONE   = ROM_ADDR_W'(1);
  localparam logic [ROM_ADDR_W-1:0] WORD_BYTES = ROM_ADDR_W'(4);

  fetch_state_e              state_q, state_d;
  logic [ROM_ADDR_W-1:0]     rom_address_q, rom_address_d;
  logic [ROM_ADDR_W-1:0]     pc_q, pc_d;
  logic [ACCEL_INSTR_W-1:0]  instr_q, instr_d;
  logic                      valid_q, valid_d;
  logic                      halted_q, halted_d;
  logic [1:0]                byte_cnt_q, byte_cnt_d;
  logic                      primed_q, primed_d;
  logic                      transfer;

  assign transfer = valid_q & instr_ready;

  always_comb begin
    state_d       = state_q;
    rom_address_d = rom_address_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    halted_d      = halted_q;
    byte_cnt_d    = byte_cnt_q;
    primed_d      = primed_q;

    case (state_q)
      ST_IDLE: begin
        rom_address_d = pc_q;
        if (enable) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        // The ROM answers one cycle late, so the first FETCH cycle only
        // issues the address; capturing starts once the pipe is primed.
        if (!primed_q) begin
          primed_d      = 1'b1;
          rom_address_d = rom_address_q + ADDR_ONE;
        end else begin
          instr_d = {instr_q[ACCEL_INSTR_W-9:0], data_from_rom};
          if (byte_cnt_q == 2'd3) begin
            state_d    = ST_HOLD;
            valid_d    = 1'b1;
            primed_d   = 1'b0;
            byte_cnt_d = 2'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q != 2'd2) rom_address_d = rom_address_q + ADDR_ONE;
          end
        end
      end

      ST_HOLD: begin
        if (transfer) begin
          valid_d       = 1'b0;
          pc_d          = pc_q + WORD_BYTES;
          rom_address_d = pc_q + WORD_BYTES;
          if (instr_q == HALT_WORD) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (enable) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_HALT: begin
      end

      default: state_d = ST_IDLE;
    endcase

    // A jump overrides whatever the FSM decided above, including a halt.
    if (redirect) begin
      state_d       = ST_FETCH;
      pc_d          = redirect_addr;
      rom_address_d = redirect_addr;
      valid_d       = 1'b0;
      halted_d      = 1'b0;
      byte_cnt_d    = 2'd0;
      primed_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rom_address_q <= START_ADDR;
      pc_q          <= START_ADDR;
      instr_q       <= '0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      byte_cnt_q    <= 2'd0;
      primed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_address_q <= rom_address_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
      byte_cnt_q    <= byte_cnt_d;
      primed_q      <= primed_d;
    end
  end

  assign rom_address    = rom_address_q;
  assign pc             = pc_q;
  assign instruction_in = instr_q;
  assign instr_valid    = valid_q;
  assign halted         = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_unit : directed + randomized bench with a ROM/word model  |
// | Revision            : 1.0                                               |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic [7:0]  rom_address;
  logic [7:0]  pc;
  logic [7:0]  data_from_rom = 8'h00;
  logic [31:0] instruction_in;
  logic        instr_valid;
  logic        halted;

  logic [7:0]  rom [256];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_pc;
  int          n;
  int          stalls;

  always #5 clk = ~clk;

  // Synchronous ROM: data reflects the address of the previous cycle.
  always @(posedge clk) data_from_rom <= rom[rom_address];

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .rom_address    (rom_address),
    .data_from_rom  (data_from_rom),
    .instruction_in (instruction_in),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .pc             (pc),
    .halted         (halted)
  );

  // Big-endian word starting at byte address a, addresses wrap at 256.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {rom[a], rom[a1], rom[a2], rom[a3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    while (instr_valid !== 1'b1 && cycles < max_cycles) begin
      step();
      cycles++;
    end
  endtask

  task automatic redirect_to(input logic [7:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    step();
    redirect      = 1'b0;
    chk("redir_rom_addr", rom_address, a);
    chk("redir_pc", pc, a);
    chk("redir_valid", instr_valid, 1'b0);
    chk("redir_halted", halted, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_addr"}, rom_address, 8'h00);
    chk({tag, "_pc"}, pc, 8'h00);
    chk({tag, "_instr"}, instruction_in, 32'h0);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; instr_ready = 1'b1;
    redirect = 1'b0; redirect_addr = 8'h00;
    // Random filler never contains 0xFF, so only the planted halt word halts.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 254));
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;
    rom[4] = 8'h9A; rom[5] = 8'hBC; rom[6] = 8'hDE; rom[7] = 8'hF0;
    for (int i = 8; i < 12; i++) rom[i] = 8'hFF;
    rom[252] = 8'hAA; rom[253] = 8'hBB; rom[254] = 8'hCC; rom[255] = 8'hDD;

    // Reset state and idle with enable low
    step();
    chk_reset_outputs("reset");
    step();
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("idle_valid", instr_valid, 1'b0);
      chk("idle_rom_addr", rom_address, 8'h00);
    end

    // Two back-to-back fetches with ready high
    exp_pc = 8'h00;
    enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("fetch_addr_seq", rom_address, 32'(exp_pc) + 32'(c));
    end
    wait_valid(20, n);
    chk("first_latency", n, 2);
    chk("word0", instruction_in, word_at(exp_pc));
    chk("word0_const", instruction_in, 32'h1234_5678);
    chk("word0_pc", pc, exp_pc);
    step();
    exp_pc += 8'd4;
    chk("after_hs_valid", instr_valid, 1'b0);
    chk("after_hs_pc", pc, exp_pc);
    wait_valid(20, n);
    chk("second_latency", n, 5);
    chk("word1", instruction_in, 32'h9ABC_DEF0);
    chk("word1_pc", pc, 8'h04);

    // Back-pressure: ten cycles of ready low in HOLD
    instr_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_word", instruction_in, word_at(exp_pc));
      chk("hold_rom_addr", rom_address, exp_pc + 8'd3);
      step();
    end
    enable = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    exp_pc += 8'd4;
    chk("hold_release_valid", instr_valid, 1'b0);
    chk("hold_release_pc", pc, exp_pc);
    chk("hold_release_rom_addr", rom_address, exp_pc);
    repeat (4) begin
      step();
      chk("idle_after_hold_valid", instr_valid, 1'b0);
      chk("idle_after_hold_pc", pc, exp_pc);
    end

    // Halt word at 0x08 stops fetching until a redirect
    enable = 1'b1;
    instr_ready = 1'b1;
    wait_valid(20, n);
    chk("halt_word_latency", n, 6);
    chk("halt_word", instruction_in, 32'hFFFF_FFFF);
    step();
    exp_pc += 8'd4;
    chk("halted_set", halted, 1'b1);
    chk("halted_valid", instr_valid, 1'b0);
    chk("halted_pc", pc, exp_pc);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("halted_rom_frozen", rom_address, exp_pc);
      chk("halted_no_valid", instr_valid, 1'b0);
      chk("halted_stays", halted, 1'b1);
    end
    instr_ready = 1'b0;
    exp_pc = 8'h00;
    redirect_to(exp_pc);
    wait_valid(20, n);
    chk("unhalt_latency", n, 5);
    chk("unhalt_word", instruction_in, 32'h1234_5678);

    // Redirect after two captured bytes, then wrap past 0xFF
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    exp_pc = 8'h04;
    step();
    step();
    step();
    chk("mid_fetch_rom_addr", rom_address, exp_pc + 8'd3);
    exp_pc = 8'hFC;
    redirect_to(exp_pc);
    wait_valid(20, n);
    chk("redir_latency", n, 5);
    chk("redir_word", instruction_in, 32'hAABB_CCDD);
    chk("redir_word_pc", pc, 8'hFC);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    exp_pc += 8'd4;
    chk("wrap_pc", pc, 8'h00);
    wait_valid(20, n);
    chk("wrap_latency", n, 5);
    chk("wrap_word", instruction_in, word_at(exp_pc));

    // Randomized stalls against the word model
    exp_pc = 8'($urandom_range(16, 100));
    redirect_to(exp_pc);
    wait_valid(20, n);
    chk("rnd_first_latency", n, 5);
    for (int i = 0; i < 20; i++) begin
      stalls = $urandom_range(0, 3);
      for (int s = 0; s < stalls; s++) begin
        chk("rnd_stall_valid", instr_valid, 1'b1);
        chk("rnd_stall_word", instruction_in, word_at(exp_pc));
        step();
      end
      chk("rnd_word", instruction_in, word_at(exp_pc));
      chk("rnd_pc", pc, exp_pc);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      exp_pc += 8'd4;
      chk("rnd_after_hs_valid", instr_valid, 1'b0);
      wait_valid(20, n);
      chk("rnd_latency", n, 5);
    end

    // Asynchronous reset in the middle of a fetch
    reset = 1'b1;
    step();
    step();
    enable = 1'b1;
    instr_ready = 1'b1;
    #3 reset = 1'b0;
    step();
    chk("post_rst_c0_addr", rom_address, 8'h00);
    step();
    step();
    chk("pre_async_rom_addr", rom_address, 8'h02);
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    #1 reset = 1'b0;

    // Enable dropped in cycle 2 of FETCH still completes the word
    step();
    exp_pc = 8'h00;
    chk("restart_c0_addr", rom_address, exp_pc);
    step();
    step();
    enable = 1'b0;
    wait_valid(20, n);
    chk("en_drop_latency", n, 3);
    chk("en_drop_word", instruction_in, 32'h1234_5678);
    step();
    exp_pc += 8'd4;
    chk("en_drop_valid", instr_valid, 1'b0);
    chk("en_drop_pc", pc, exp_pc);
    chk("en_drop_rom_addr", rom_address, exp_pc);
    repeat (10) begin
      step();
      chk("en_drop_idle_valid", instr_valid, 1'b0);
      chk("en_drop_idle_rom_addr", rom_address, exp_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
